// File: rtl/event_pkg.sv
// Shared definitions for the event round-robin scheduler.
//
// Contents:
//   EVT_MAX_CH  largest supported channel count
//   EVT_ID_W    index width wide enough for EVT_MAX_CH channels
//   evt_rec_t   one presented event: channel index plus level after the edge
//   rr_res_t    result of a round-robin search: found flag plus index
//   rr_next     round-robin search over a request vector
package event_pkg;

  localparam int EVT_MAX_CH = 16;
  localparam int EVT_ID_W   = 4;

  typedef struct packed {
    logic [EVT_ID_W-1:0] ch_id;
    logic                level;
  } evt_rec_t;

  typedef struct packed {
    logic                found;
    logic [EVT_ID_W-1:0] idx;
  } rr_res_t;

  // Search for the first set request strictly after ptr, wrapping around.
  // The request vector is zero-padded to EVT_MAX_CH, and padded bits are
  // never set. So wrapping modulo EVT_MAX_CH visits the real channels in
  // the same order as wrapping modulo the real channel count would.
  function automatic rr_res_t rr_next(input logic [EVT_MAX_CH-1:0] req,
                                      input logic [EVT_ID_W-1:0]   ptr);
    rr_res_t             res;
    logic [EVT_ID_W-1:0] cand;
    res = '0;
    for (int k = 1; k <= EVT_MAX_CH; k++) begin
      cand = ptr + EVT_ID_W'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//
// Ports:
//   req_i       request vector, one bit per channel
//   ptr_i       index of the last granted channel; the search starts after it
//   enable_i    when low, nothing is granted
//   grant_o     one-hot grant
//   grantIdx_o  binary index of the granted channel (0 when no grant)
//   anyGrant_o  a grant was issued
module rr_arbiter
  import event_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grantIdx_o,
  output logic          anyGrant_o
);

  rr_res_t res;
  logic    hit;

  // The range check on res.idx never removes a real grant. It keeps the
  // index provably below N when N is not a power of two.
  always_comb begin
    res        = rr_next(EVT_MAX_CH'(req_i), EVT_ID_W'(ptr_i));
    hit        = enable_i && res.found && (32'(res.idx) < N);
    anyGrant_o = hit;
    grantIdx_o = hit ? res.idx[IW-1:0] : '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = hit && (32'(res.idx) == i);
    end
  end

endmodule

// File: rtl/event_rr_scheduler.sv
// Multi-channel event capture and round-robin scheduling controller.
// Each channel has an XOR edge detector. A detected edge is latched as a
// pending request and later presented on a single valid/ready output port.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   i_Data      per-channel event lines, already synchronous to clk
//   i_Mask      1 = channel may capture new edges
//   i_Ready     downstream accepts the presented event
//   i_Ovf_Clr   pulse that clears all overflow bits
//   o_Valid     an event is presented
//   o_Ch_Id     channel index of the presented event
//   o_Level     i_Data level after the edge (1 = rising)
//   o_Overflow  sticky per-channel "edge lost" flags
module event_rr_scheduler
  import event_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] i_Data,
  input  logic [N_CH-1:0] i_Mask,
  input  logic            i_Ready,
  input  logic            i_Ovf_Clr,
  output logic            o_Valid,
  output logic [ID_W-1:0] o_Ch_Id,
  output logic            o_Level,
  output logic [N_CH-1:0] o_Overflow
);

  logic [N_CH-1:0] dataFf_q;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] pendLvl_q, pendLvl_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] chId_q, chId_d;
  logic            level_q, level_d;
  logic [ID_W-1:0] rrPtr_q, rrPtr_d;

  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] keep;
  logic            slotFree;
  logic [N_CH-1:0] grantOh;
  logic [ID_W-1:0] grantIdx;
  logic            anyGrant;

  // A grant is issued only when the output slot can accept a new event.
  rr_arbiter #(
    .N  (N_CH),
    .IW (ID_W)
  ) uArb (
    .req_i      (pending_q),
    .ptr_i      (rrPtr_q),
    .enable_i   (slotFree),
    .grant_o    (grantOh),
    .grantIdx_o (grantIdx),
    .anyGrant_o (anyGrant)
  );

  always_comb begin
    ev       = (i_Data ^ dataFf_q) & i_Mask;
    slotFree = !valid_q || i_Ready;

    valid_d = valid_q;
    chId_d  = chId_q;
    level_d = level_q;
    rrPtr_d = rrPtr_q;
    if (slotFree) begin
      if (anyGrant) begin
        valid_d = 1'b1;
        chId_d  = grantIdx;
        level_d = pendLvl_q[grantIdx];
        rrPtr_d = grantIdx;
      end else begin
        valid_d = 1'b0;
      end
    end

    // keep = pending requests that survive this cycle. A new edge on a
    // surviving request is lost. A new edge on a channel being granted
    // takes over the freed slot with its own level.
    keep      = pending_q & ~grantOh;
    pending_d = keep | ev;
    for (int i = 0; i < N_CH; i++) begin
      pendLvl_d[i] = (ev[i] && !keep[i]) ? i_Data[i] : pendLvl_q[i];
    end

    // A new overflow on the same cycle as a clear must survive.
    ovf_d = (i_Ovf_Clr ? '0 : ovf_q) | (ev & keep);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataFf_q  <= '0;
      pending_q <= '0;
      pendLvl_q <= '0;
      ovf_q     <= '0;
      valid_q   <= 1'b0;
      chId_q    <= '0;
      level_q   <= 1'b0;
      rrPtr_q   <= ID_W'(N_CH - 1);
    end else begin
      dataFf_q  <= i_Data;
      pending_q <= pending_d;
      pendLvl_q <= pendLvl_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      chId_q    <= chId_d;
      level_q   <= level_d;
      rrPtr_q   <= rrPtr_d;
    end
  end

  assign o_Valid    = valid_q;
  assign o_Ch_Id    = chId_q;
  assign o_Level    = level_q;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_event_rr_scheduler.sv
// Self-checking bench for event_rr_scheduler with four channels.
// A behavioural model runs alongside the design and is compared with the
// outputs on every falling clock edge. Directed scenarios also check
// hand-computed values.
module tb_event_rr_scheduler;
  import event_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] i_Data;
  logic [N-1:0] i_Mask;
  logic         i_Ready;
  logic         i_Ovf_Clr;
  logic         o_Valid;
  logic [1:0]   o_Ch_Id;
  logic         o_Level;
  logic [N-1:0] o_Overflow;

  int nChecks = 0;
  int nFails  = 0;

  event_rr_scheduler #(.N_CH(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_Data     (i_Data),
    .i_Mask     (i_Mask),
    .i_Ready    (i_Ready),
    .i_Ovf_Clr  (i_Ovf_Clr),
    .o_Valid    (o_Valid),
    .o_Ch_Id    (o_Ch_Id),
    .o_Level    (o_Level),
    .o_Overflow (o_Overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [N-1:0] mPrev  = '0;
  logic [N-1:0] mPend  = '0;
  logic [N-1:0] mLvl   = '0;
  logic [N-1:0] mOvf   = '0;
  logic         mValid = 1'b0;
  evt_rec_t     mRec   = '0;
  int           mPtr   = N - 1;

  // Model: a free slot takes the first pending channel after the last
  // grant. An edge on a channel that still waits is lost and flagged. An
  // edge on a channel just granted becomes its new request.
  always @(posedge clk or negedge reset_n) begin
    int  gnt;
    bit  free;
    if (!reset_n) begin
      mPrev  = '0;
      mPend  = '0;
      mLvl   = '0;
      mOvf   = '0;
      mValid = 1'b0;
      mRec   = '0;
      mPtr   = N - 1;
    end else begin
      free = !mValid || i_Ready;
      gnt  = -1;
      if (free) begin
        for (int k = 1; k <= N; k++) begin
          if (gnt < 0 && mPend[(mPtr + k) % N]) gnt = (mPtr + k) % N;
        end
        if (gnt >= 0) begin
          mValid     = 1'b1;
          mRec.ch_id = EVT_ID_W'(gnt);
          mRec.level = mLvl[gnt];
          mPtr       = gnt;
          mPend[gnt] = 1'b0;
        end else begin
          mValid = 1'b0;
        end
      end
      if (i_Ovf_Clr) mOvf = '0;
      for (int i = 0; i < N; i++) begin
        if (i_Mask[i] && (i_Data[i] != mPrev[i])) begin
          if (mPend[i]) begin
            mOvf[i] = 1'b1;
          end else begin
            mPend[i] = 1'b1;
            mLvl[i]  = i_Data[i];
          end
        end
      end
      mPrev = i_Data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare the design against the model on every falling edge
  always @(negedge clk) begin
    checkOutput("model valid", 32'(o_Valid), 32'(mValid));
    checkOutput("model overflow", 32'(o_Overflow), 32'(mOvf));
    if (mValid) begin
      checkOutput("model chId", 32'(o_Ch_Id), 32'(mRec.ch_id));
      checkOutput("model level", 32'(o_Level), 32'(mRec.level));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] data, input logic [N-1:0] mask,
                               input logic ready, input logic clr);
    i_Data    = data;
    i_Mask    = mask;
    i_Ready   = ready;
    i_Ovf_Clr = clr;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset is asserted shortly after a falling edge so that it never races
  // the compare process.
  task automatic resetDut();
    applyStimulus('0, '1, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic checkEvent(input string name, input int id, input logic lvl);
    checkOutput({name, " valid"}, 32'(o_Valid), 32'd1);
    checkOutput({name, " id"}, 32'(o_Ch_Id), 32'(id));
    checkOutput({name, " level"}, 32'(o_Level), 32'(lvl));
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus('0, '1, 1'b1, 1'b0);
    step(2);
    checkOutput("reset valid", 32'(o_Valid), 32'd0);
    checkOutput("reset chId", 32'(o_Ch_Id), 32'd0);
    checkOutput("reset level", 32'(o_Level), 32'd0);
    checkOutput("reset overflow", 32'(o_Overflow), 32'd0);
    reset_n = 1'b1;
    step(1);

    // Single rising edge on ch1: visible two cycles later for one cycle
    applyStimulus(4'b0010, 4'b1111, 1'b1, 1'b0);
    step(1);
    checkOutput("t1 latency", 32'(o_Valid), 32'd0);
    step(1);
    checkEvent("t1 event", 1, 1'b1);
    step(1);
    checkOutput("t1 drop", 32'(o_Valid), 32'd0);

    // Simultaneous bursts: ids 0..3 each time
    resetDut();
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(1);
    for (int k = 0; k < N; k++) begin
      step(1);
      checkEvent("t2 rise burst", k, 1'b1);
    end
    step(1);
    checkOutput("t2 idle", 32'(o_Valid), 32'd0);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    step(1);
    for (int k = 0; k < N; k++) begin
      step(1);
      checkEvent("t2 fall burst", k, 1'b0);
    end
    step(1);

    // Back-pressure: ch2 rise is held, fall queues, second rise is lost
    applyStimulus(4'b0100, 4'b1111, 1'b0, 1'b0);
    step(2);
    checkEvent("t3 held", 2, 1'b1);
    step(1);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0);
    step(2);
    applyStimulus(4'b0100, 4'b1111, 1'b0, 1'b0);
    step(1);
    checkOutput("t3 overflow", 32'(o_Overflow), 32'b0100);
    checkEvent("t3 still held", 2, 1'b1);
    applyStimulus(4'b0100, 4'b1111, 1'b0, 1'b1);
    step(1);
    checkOutput("t3 ovf clear", 32'(o_Overflow), 32'd0);
    applyStimulus(4'b0100, 4'b1111, 1'b1, 1'b0);
    step(1);
    checkEvent("t3 first level kept", 2, 1'b0);
    step(1);
    checkOutput("t3 drained", 32'(o_Valid), 32'd0);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    step(4);

    // Masked channel: toggles ignored, re-enable with stable level is quiet
    applyStimulus(4'b1000, 4'b0111, 1'b1, 1'b0);
    step(1);
    applyStimulus(4'b0000, 4'b0111, 1'b1, 1'b0);
    step(1);
    applyStimulus(4'b1000, 4'b0111, 1'b1, 1'b0);
    step(2);
    checkOutput("t4 masked", 32'(o_Valid), 32'd0);
    applyStimulus(4'b1000, 4'b1111, 1'b1, 1'b0);
    step(3);
    checkOutput("t4 no spurious", 32'(o_Valid), 32'd0);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    step(2);
    checkEvent("t4 unmasked fall", 3, 1'b0);
    step(1);

    // Edge on ch0 during its own grant cycle is kept, not an overflow
    applyStimulus(4'b0001, 4'b1111, 1'b1, 1'b0);
    step(1);
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0);
    step(1);
    checkEvent("t5 first", 0, 1'b1);
    step(1);
    checkEvent("t5 second", 0, 1'b0);
    checkOutput("t5 no overflow", 32'(o_Overflow), 32'd0);
    step(2);

    // Reset in the middle of a burst with all inputs held high
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6 async valid", 32'(o_Valid), 32'd0);
    checkOutput("t6 async chId", 32'(o_Ch_Id), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    checkOutput("t6 post-release", 32'(o_Valid), 32'd0);
    for (int k = 0; k < N; k++) begin
      step(1);
      checkEvent("t6 replay", k, 1'b1);
    end
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
